// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

   // Prefix bytes folded into flags instead of being queued.
   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Queued entry: {ext, break, scancode}.
   localparam int ENTRY_W = 10;

   // Deframer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2State_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a saturating-count glitch filter.
// The filtered output only follows the pin after FILTER_LEN consecutive
// synchronized samples disagree with it; shorter pulses are discarded.
module ps2_sync_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pinIn,
   output logic filtOut
);

   logic       sync1;
   logic       sync2;
   logic [3:0] cnt;

   // Synchronize the asynchronous pin; idle level of a PS/2 line is 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= pinIn;
         sync2 <= sync1;
      end
   end

   // Count disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= 4'd0;
         filtOut <= 1'b1;
      end else if (sync2 == filtOut) begin
         cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
         cnt     <= 4'd0;
         filtOut <= sync2;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions KBD_CLK/KBD_DATA, deframes 11-bit
// frames, folds E0/F0 prefixes into flags and queues scancodes in a FIFO.
//
// Output handshake: scanValid is high whenever the FIFO holds an entry and
// the head {scanExt, scanBreak, scanCode} is held stable until a cycle with
// scanValid & scanReady, which pops it; scanValid does not depend on scanReady.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       KBD_CLK,
   input  logic       KBD_DATA,
   output logic [7:0] scanCode,
   output logic       scanExt,
   output logic       scanBreak,
   output logic       scanValid,
   input  logic       scanReady,
   output logic       frameError,
   output logic       overflow,
   output logic [1:0] dbgState
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic              kbdClkF;
   logic              kbdDataF;
   logic              clkPrev;
   logic              fallTick;
   ps2State_t         state;
   logic [2:0]        bitCnt;
   logic [7:0]        shiftReg;
   logic              parityBit;
   logic [TO_W-1:0]   toCnt;
   logic              extF;
   logic              brkF;
   logic              stopOk;
   logic              deliver;
   logic              frameErr;
   logic              timeoutHit;
   logic              pushReq;
   logic              doPush;
   logic              doPop;
   logic              empty;
   logic              full;
   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wPtr;
   logic [AW:0]       rPtr;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) uClkFilt (
      .clk(clk), .rst(rst), .pinIn(KBD_CLK), .filtOut(kbdClkF)
   );

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) uDataFilt (
      .clk(clk), .rst(rst), .pinIn(KBD_DATA), .filtOut(kbdDataF)
   );

   // Registered one-cycle tick on each 1->0 transition of the filtered clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkPrev  <= 1'b1;
         fallTick <= 1'b0;
      end else begin
         clkPrev  <= kbdClkF;
         fallTick <= clkPrev & ~kbdClkF;
      end
   end

   // Frame outcome decode; a fallTick wins over a coincident timeout.
   always_comb begin
      stopOk     = kbdDataF & (^{shiftReg, parityBit});
      timeoutHit = (state != IDLE) && !fallTick && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
      deliver    = fallTick && (state == STOP) && stopOk;
      frameErr   = (fallTick && (state == STOP) && !stopOk) || timeoutHit;
      pushReq    = deliver && (shiftReg != PS2_EXT) && (shiftReg != PS2_BRK);
      doPop      = scanValid & scanReady;
      doPush     = pushReq & (~full | doPop);
   end

   // Deframer FSM: advances on fallTick, aborts to IDLE on timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bitCnt     <= 3'd0;
         shiftReg   <= 8'd0;
         parityBit  <= 1'b0;
         frameError <= 1'b0;
      end else begin
         frameError <= frameErr;
         if (timeoutHit) begin
            state <= IDLE;
         end else if (fallTick) begin
            case (state)
               IDLE: begin
                  bitCnt <= 3'd0;
                  if (!kbdDataF) state <= DATA;
               end
               DATA: begin
                  shiftReg <= {kbdDataF, shiftReg[7:1]};
                  bitCnt   <= bitCnt + 3'd1;
                  if (bitCnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  parityBit <= kbdDataF;
                  state     <= STOP;
               end
               STOP: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Inter-edge timeout counter, held at zero while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toCnt <= '0;
      end else if (fallTick || (state == IDLE) || timeoutHit) begin
         toCnt <= '0;
      end else begin
         toCnt <= toCnt + 1'b1;
      end
   end

   // Prefix flags: set by E0/F0, cleared by any other byte or a frame error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         extF <= 1'b0;
         brkF <= 1'b0;
      end else if (frameErr) begin
         extF <= 1'b0;
         brkF <= 1'b0;
      end else if (deliver) begin
         if (shiftReg == PS2_EXT) begin
            extF <= 1'b1;
         end else if (shiftReg == PS2_BRK) begin
            brkF <= 1'b1;
         end else begin
            extF <= 1'b0;
            brkF <= 1'b0;
         end
      end
   end

   // Scancode FIFO with wrap-bit pointers; overflow drops the new entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wPtr     <= '0;
         rPtr     <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         overflow <= pushReq & full & ~doPop;
         if (doPush) begin
            mem[wPtr[AW-1:0]] <= {extF, brkF, shiftReg};
            wPtr              <= wPtr + 1'b1;
         end
         if (doPop) rPtr <= rPtr + 1'b1;
      end
   end

   assign empty     = (wPtr == rPtr);
   assign full      = (wPtr[AW] != rPtr[AW]) && (wPtr[AW-1:0] == rPtr[AW-1:0]);
   assign scanValid = ~empty;
   assign {scanExt, scanBreak, scanCode} = mem[rPtr[AW-1:0]];
   assign dbgState  = state;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed plus randomized bench for ps2_kbd_rx with a byte-level model.
module tb_ps2_kbd_rx;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 200;
  localparam int DEPTH      = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       kbd_clk;
  logic       kbd_data;
  logic [7:0] scan_code;
  logic       scan_ext;
  logic       scan_break;
  logic       scan_valid;
  logic       scan_ready;
  logic       frame_error;
  logic       overflow;
  logic [1:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cnt      = 0;
  int ovf_cnt     = 0;
  int exp_fe      = 0;
  int exp_ovf     = 0;
  int valid_lat   = 0;
  logic ext_m     = 1'b0;
  logic brk_m     = 1'b0;
  logic [9:0] exp_q[$];

  ps2_kbd_rx #(
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .KBD_CLK(kbd_clk), .KBD_DATA(kbd_data),
    .scanCode(scan_code), .scanExt(scan_ext), .scanBreak(scan_break),
    .scanValid(scan_valid), .scanReady(scan_ready),
    .frameError(frame_error), .overflow(overflow), .dbgState(dbg_state)
  );

  // clock / reset
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: what a correct receiver does with one received frame
  task automatic model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_fe++;
      ext_m = 1'b0;
      brk_m = 1'b0;
    end else if (b == 8'hE0) begin
      ext_m = 1'b1;
    end else if (b == 8'hF0) begin
      brk_m = 1'b1;
    end else begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({ext_m, brk_m, b});
      ext_m = 1'b0;
      brk_m = 1'b0;
    end
  endtask

  // driver: sends the first n_bits bits of a frame, 400 ns half period
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch, input int n_bits = 11);
    logic [10:0] bits;
    bit          v_before;
    bits      = {1'b1, (~^b) ^ flip, b, 1'b0};
    valid_lat = 0;
    for (int i = 0; i < n_bits; i++) begin
      kbd_data = bits[i];
      tick(3);
      if (glitch && i == 4) begin
        kbd_clk = 1'b0;
        tick(2);
        kbd_clk = 1'b1;
      end else begin
        tick(2);
      end
      tick(5);
      kbd_clk = 1'b0;
      if (i == 10) model_frame(b, flip);
      v_before = scan_valid;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (i == 10 && !v_before && scan_valid && valid_lat == 0) valid_lat = j;
      end
      kbd_clk = 1'b1;
    end
    kbd_data = 1'b1;
    tick(10);
  endtask

  // scoreboard: every pop must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_error) fe_cnt++;
      if (overflow) ovf_cnt++;
      if (scan_valid && scan_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", {6'd0, scan_ext, scan_break, scan_code}, 16'hFFFF);
        else chk("pop_entry", {6'd0, scan_ext, scan_break, scan_code}, {6'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] code;
    bit         flip;
    rst = 1'b1; kbd_clk = 1'b1; kbd_data = 1'b1; scan_ready = 1'b0;
    tick(3);
    chk("rst_valid", {15'd0, scan_valid}, 16'd0);
    chk("rst_head", {6'd0, scan_ext, scan_break, scan_code}, 16'd0);
    chk("rst_pulses", {14'd0, frame_error, overflow}, 16'd0);
    chk("rst_state", {14'd0, dbg_state}, {14'd0, IDLE});
    rst = 1'b0;
    tick(5);

    // key 'A' make, latency from STOP fall, head held while not ready
    send_frame(8'h1C, 0, 0);
    chk("make_latency", 16'(valid_lat), 16'd8);
    chk("make_head", {6'd0, scan_ext, scan_break, scan_code}, 16'h001C);
    tick(20);
    chk("make_hold", {6'd0, scan_ext, scan_break, scan_code}, 16'h001C);
    scan_ready = 1'b1;
    tick(3);
    chk("make_drained", {15'd0, scan_valid}, 16'd0);

    // release and extended release
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);

    // parity error after a break prefix, then a clean 0x32
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h32, 0, 0);
    chk("parity_fe", 16'(fe_cnt), 16'(exp_fe));

    // timeout mid-frame after an E0 prefix
    send_frame(8'hE0, 0, 0);
    send_frame(8'h00, 0, 0, 6);
    tick(TIMEOUT + 50);
    exp_fe++; ext_m = 1'b0; brk_m = 1'b0;
    chk("timeout_fe", 16'(fe_cnt), 16'(exp_fe));
    chk("timeout_idle", {14'd0, dbg_state}, {14'd0, IDLE});
    send_frame(8'h15, 0, 0);

    // overflow: five codes into a four-deep FIFO
    scan_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 0, 0);
    chk("ovf_count", 16'(ovf_cnt), 16'(exp_ovf));
    chk("ovf_head", {6'd0, scan_ext, scan_break, scan_code}, 16'h0001);
    scan_ready = 1'b1;
    tick(8);
    chk("ovf_drained", {15'd0, scan_valid}, 16'd0);
    chk("ovf_queue", 16'(exp_q.size()), 16'd0);

    // glitches on KBD_CLK do not add bits
    send_frame(8'hA5, 0, 1);
    send_frame(8'h5A, 0, 1);

    // reset mid-frame with an entry queued
    scan_ready = 1'b0;
    send_frame(8'h2A, 0, 0);
    send_frame(8'h33, 0, 0, 5);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_valid", {15'd0, scan_valid}, 16'd0);
    chk("mid_rst_head", {6'd0, scan_ext, scan_break, scan_code}, 16'd0);
    chk("mid_rst_state", {14'd0, dbg_state}, {14'd0, IDLE});
    rst = 1'b0;
    exp_q.delete(); ext_m = 1'b0; brk_m = 1'b0;
    scan_ready = 1'b1;
    tick(5);
    send_frame(8'h4B, 0, 0);

    // randomized prefixes, codes, parity faults and glitches
    for (int n = 0; n < 12; n++) begin
      code = 8'($urandom_range(1, 8'hDF));
      if ($urandom_range(0, 1) == 1) send_frame(8'hE0, 0, 0);
      if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 0, 0);
      flip = ($urandom_range(0, 7) == 0);
      send_frame(code, flip, 1'($urandom_range(0, 1)));
    end

    tick(20);
    chk("final_fe", 16'(fe_cnt), 16'(exp_fe));
    chk("final_ovf", 16'(ovf_cnt), 16'(exp_ovf));
    chk("final_queue", 16'(exp_q.size()), 16'd0);
    chk("final_valid", {15'd0, scan_valid}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
